// File: rtl/dvp_capture_controller_if.sv
// Bundle between the DVP capture controller and its environment (loader, frame-buffer port, host control).
// slave = controller side, master = driver/environment side.
interface dvp_capture_controller_if #(
  parameter int ADDR_W = 17
);
  logic              start;
  logic              abort;
  logic              href;
  logic              vsynch;
  logic              pix_valid;
  logic [15:0]       pix_data;
  logic              loader_enable;
  logic              loader_reset;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              busy;
  logic              frame_done;
  logic [3:0]        err_flags;

  modport slave (
    input  start, abort, href, vsynch, pix_valid, pix_data, wr_ready,
    output loader_enable, loader_reset, wr_en, wr_addr, wr_data, busy, frame_done, err_flags
  );

  modport master (
    output start, abort, href, vsynch, pix_valid, pix_data, wr_ready,
    input  loader_enable, loader_reset, wr_en, wr_addr, wr_data, busy, frame_done, err_flags
  );
endinterface

// File: rtl/dvp_capture_controller.sv
// Sequences a single RGB565 DVP frame capture into linear frame-buffer writes (addr = line*H_PIXELS+col).
// Optional watchdog enabled by defining CAPTURE_TIMEOUT_EN; otherwise err_flags[3] is tied 0.
module dvp_capture_controller #(
  parameter int          H_PIXELS = 320,
  parameter int          V_LINES  = 240,
  parameter int          ADDR_W   = 17,
  parameter logic [23:0] TIMEOUT  = 24'd5_000_000
) (
  input logic                     clk,
  input logic                     reset,
  dvp_capture_controller_if.slave bus
);

  localparam int                COL_W    = $clog2(H_PIXELS + 1);
  localparam int                LINE_W   = $clog2(V_LINES + 1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(H_PIXELS);
  localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_LINES);
  localparam logic [ADDR_W-1:0] H_STEP   = ADDR_W'(H_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_BLANK,
    S_WAIT_FRAME,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [COL_W-1:0]    col_q;
  logic [LINE_W-1:0]   line_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   line_base_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [15:0]         wr_data_q;
  logic [2:0]          err_q;
  logic                frame_done_q;
  logic                loader_enable_q;
  logic                loader_reset_q;
  logic                href_q;
  logic                vsynch_q;

  logic                pend;
  logic                href_fall;
  logic                vs_rise;
  logic [LINE_W-1:0]   line_d;
  logic [ADDR_W-1:0]   base_d;
  logic                timeout_flag;

  // A write is still outstanding when the memory has not taken it this cycle.
  assign pend      = wr_en_q & ~bus.wr_ready;
  assign href_fall = href_q & ~bus.href;
  assign vs_rise   = bus.vsynch & ~vsynch_q;
  assign line_d    = line_q + 1'b1;
  assign base_d    = line_base_q + H_STEP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      href_q   <= 1'b0;
      vsynch_q <= 1'b0;
    end else begin
      href_q   <= bus.href;
      vsynch_q <= bus.vsynch;
    end
  end

`ifdef CAPTURE_TIMEOUT_EN
  logic        timeout_hit;
  logic        watching;
  logic        start_acc;
  logic [23:0] to_cnt_q;
  state_t      state_p_q;
  logic        to_err_q;

  assign watching    = (state_q == S_WAIT_BLANK) || (state_q == S_WAIT_FRAME) ||
                       (state_q == S_CAPTURE);
  assign timeout_hit = watching && (to_cnt_q == TIMEOUT);
  assign start_acc   = bus.start && !bus.abort && (state_q == S_IDLE);

  // Counter restarts on any pixel and on the first cycle of every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q  <= '0;
      state_p_q <= S_IDLE;
      to_err_q  <= 1'b0;
    end else begin
      state_p_q <= state_q;
      if (!watching || bus.pix_valid || (state_q != state_p_q)) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != TIMEOUT) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (start_acc) begin
        to_err_q <= 1'b0;
      end else if (timeout_hit && !bus.abort) begin
        to_err_q <= 1'b1;
      end
    end
  end

  assign timeout_flag = to_err_q;
`else
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      col_q           <= '0;
      line_q          <= '0;
      addr_q          <= '0;
      line_base_q     <= '0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      err_q           <= '0;
      frame_done_q    <= 1'b0;
      loader_enable_q <= 1'b0;
      loader_reset_q  <= 1'b1;
    end else begin
      frame_done_q <= 1'b0;
      if (wr_en_q && bus.wr_ready) begin
        wr_en_q <= 1'b0;
      end

      if (bus.abort) begin
        state_q         <= S_IDLE;
        wr_en_q         <= 1'b0;
        loader_enable_q <= 1'b0;
        loader_reset_q  <= 1'b1;
      end
`ifdef CAPTURE_TIMEOUT_EN
      else if (timeout_hit) begin
        state_q <= S_DONE;
      end
`endif
      else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              state_q         <= S_ARM;
              err_q           <= '0;
              col_q           <= '0;
              line_q          <= '0;
              addr_q          <= '0;
              line_base_q     <= '0;
              loader_reset_q  <= 1'b0;
              loader_enable_q <= 1'b1;
            end
          end

          S_ARM: state_q <= S_WAIT_BLANK;

          // Require a blanking interval first so capture never begins mid-frame.
          S_WAIT_BLANK: begin
            if (bus.vsynch) state_q <= S_WAIT_FRAME;
          end

          S_WAIT_FRAME: begin
            if (!bus.vsynch) state_q <= S_CAPTURE;
          end

          S_CAPTURE: begin
            if (bus.pix_valid) begin
              if (col_q == COL_MAX) begin
                err_q[1] <= 1'b1;
              end else begin
                if (pend) begin
                  err_q[0] <= 1'b1;
                end else begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= addr_q;
                  wr_data_q <= bus.pix_data;
                end
                addr_q <= addr_q + 1'b1;
                col_q  <= col_q + 1'b1;
              end
            end

            // Line end realigns the address so a bad line cannot skew the rest of the frame.
            if (href_fall) begin
              if (col_q != COL_MAX) err_q[1] <= 1'b1;
              col_q  <= '0;
              line_q <= line_d;
              if (line_d == LINE_MAX) begin
                state_q <= S_DONE;
              end else begin
                addr_q      <= base_d;
                line_base_q <= base_d;
              end
            end else if (vs_rise) begin
              err_q[2] <= 1'b1;
              state_q  <= S_DONE;
            end
          end

          S_DONE: begin
            if (!pend) begin
              frame_done_q    <= 1'b1;
              loader_enable_q <= 1'b0;
              loader_reset_q  <= 1'b1;
              state_q         <= S_IDLE;
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.loader_enable = loader_enable_q;
  assign bus.loader_reset  = loader_reset_q;
  assign bus.wr_en         = wr_en_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.frame_done    = frame_done_q;
  assign bus.err_flags     = {timeout_flag, err_q};

endmodule

// File: tb/tb_dvp_capture_controller.sv
// Directed + randomized bench for dvp_capture_controller on a reduced 16x8 frame.
module tb_dvp_capture_controller;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int AW = 7;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dvp_capture_controller_if #(.ADDR_W(AW)) bus ();

  dvp_capture_controller #(
    .H_PIXELS(H),
    .V_LINES (V),
    .ADDR_W  (AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int  checks = 0;
  int  errors = 0;
  int  fd_cnt = 0;
  int  wr_cnt = 0;
  int  fd_base, wr_base;
  bit  rnd_ready = 1'b0;
  int  lows = 0;
  wr_t exp_q[$];
  wr_t e_mon;

  // Reference model: a frame is a list of lines; each line fills addresses line*H .. line*H+H-1.
  int  m_line, m_col, m_wr;
  bit  m_ll, m_ovf, m_short;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory side: count accepted writes and compare them in order against the model.
  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (bus.wr_en === 1'b1 && bus.wr_ready === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        e_mon = exp_q.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(e_mon.addr));
        check("wr_data", 32'(bus.wr_data), 32'(e_mon.data));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_ready) begin
        if (lows >= 2 || $urandom_range(0, 2) != 0) begin
          bus.wr_ready = 1'b1;
          lows = 0;
        end else begin
          bus.wr_ready = 1'b0;
          lows++;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_line = 0; m_col = 0; m_wr = 0;
    m_ll = 1'b0; m_ovf = 1'b0; m_short = 1'b0;
    fd_base = fd_cnt;
    wr_base = wr_cnt;
  endtask

  // One pixel pulse; drop=1 means the model expects it lost to a still-pending write.
  task automatic pixel(input int gap, input bit expect_wr, input bit drop);
    logic [15:0]   d;
    logic [AW-1:0] a;
    bit            pushed;
    d = 16'($urandom);
    a = '0;
    pushed = 1'b0;
    if (expect_wr) begin
      if (m_col < H) begin
        a = AW'(m_line * H + m_col);
        if (drop) begin
          m_ovf = 1'b1;
        end else begin
          exp_q.push_back('{addr: a, data: d});
          m_wr++;
          pushed = 1'b1;
        end
        m_col++;
      end else begin
        m_ll = 1'b1;
      end
    end
    bus.pix_data  = d;
    bus.pix_valid = 1'b1;
    tick(1);
    bus.pix_valid = 1'b0;
    if (pushed) begin
      check("lat_wr_en", 32'(bus.wr_en), 32'd1);
      check("lat_wr_addr", 32'(bus.wr_addr), 32'(a));
      check("lat_wr_data", 32'(bus.wr_data), 32'(d));
    end
    tick(gap - 1);
  endtask

  task automatic send_line(input int len, input bit expect_wr);
    if (expect_wr) m_col = 0;
    bus.href = 1'b1;
    tick(1);
    for (int i = 0; i < len; i++) pixel($urandom_range(4, 6), expect_wr, 1'b0);
    bus.href = 1'b0;
    if (expect_wr) begin
      if (len != H) m_ll = 1'b1;
      m_line++;
    end
    tick(3);
  endtask

  task automatic frame_start();
    model_reset();
    bus.vsynch = 1'b1;
    bus.start  = 1'b1;
    tick(1);
    bus.start  = 1'b0;
    check("arm_busy", 32'(bus.busy), 32'd1);
    check("arm_loader_enable", 32'(bus.loader_enable), 32'd1);
    check("arm_loader_reset", 32'(bus.loader_reset), 32'd0);
    check("arm_err_cleared", 32'(bus.err_flags), 32'd0);
    tick(3);
    bus.vsynch = 1'b0;
    tick(2);
  endtask

  task automatic frame_finish(input string tag);
    if (m_line < V) m_short = 1'b1;
    bus.vsynch = 1'b1;
    for (int i = 0; i < 300 && fd_cnt == fd_base; i++) tick(1);
    tick(3);
    check({tag, "_frame_done"}, 32'(fd_cnt - fd_base), 32'd1);
    check({tag, "_writes"}, 32'(wr_cnt - wr_base), 32'(m_wr));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_err"}, 32'(bus.err_flags), 32'({1'b0, m_short, m_ll, m_ovf}));
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_loader_reset"}, 32'(bus.loader_reset), 32'd1);
    check({tag, "_loader_enable"}, 32'(bus.loader_enable), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_loader_reset"}, 32'(bus.loader_reset), 32'd1);
    check({tag, "_loader_enable"}, 32'(bus.loader_enable), 32'd0);
    check({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.href      = 1'b0;
    bus.vsynch    = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.wr_ready  = 1'b1;
    tick(3);
    check_idle_outputs("reset");
    check("reset_err", 32'(bus.err_flags), 32'd0);
    reset = 1'b0;
    tick(2);
    check_idle_outputs("post_reset");

    // Full frame with an always-ready memory.
    frame_start();
    for (int l = 0; l < V; l++) send_line(H, 1'b1);
    check("full_writes", 32'(wr_cnt - wr_base), 32'(H * V));
    frame_finish("full");

    // Overflow: memory stalls while the second pixel arrives.
    frame_start();
    bus.wr_ready = 1'b0;
    m_col = 0;
    bus.href = 1'b1;
    tick(1);
    pixel(2, 1'b1, 1'b0);
    pixel(1, 1'b1, 1'b1);
    check("ovf_hold_en", 32'(bus.wr_en), 32'd1);
    check("ovf_hold_addr", 32'(bus.wr_addr), 32'd0);
    bus.wr_ready = 1'b1;
    tick(1);
    check("ovf_released", 32'(bus.wr_en), 32'd0);
    for (int i = 2; i < H; i++) pixel(4, 1'b1, 1'b0);
    bus.href = 1'b0;
    m_line++;
    tick(3);
    frame_finish("overflow");

    // Short line then realignment to the next line's base address.
    frame_start();
    send_line(H - 1, 1'b1);
    for (int l = 1; l < V; l++) send_line(H, 1'b1);
    frame_finish("short_line");

    // Frame cut short by vsynch after 3 lines.
    frame_start();
    for (int l = 0; l < 3; l++) send_line(H, 1'b1);
    frame_finish("short_frame");
    check("short_frame_count", 32'(m_wr), 32'(3 * H));

    // Randomized frames: random line lengths, line counts and memory stalls.
    rnd_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      int nl;
      frame_start();
      nl = $urandom_range(1, V);
      if (f == 0) nl = V;
      for (int l = 0; l < nl; l++) begin
        int r;
        r = $urandom_range(0, 5);
        send_line((r == 0) ? H - 1 : (r == 1) ? H + 1 : H, 1'b1);
      end
      frame_finish("random");
    end
    rnd_ready = 1'b0;
    bus.wr_ready = 1'b1;

    // Start during an active frame: nothing written until a full blank/active transition; then abort.
    model_reset();
    bus.vsynch = 1'b0;
    bus.start  = 1'b1;
    tick(1);
    bus.start  = 1'b0;
    check("mid_busy", 32'(bus.busy), 32'd1);
    tick(3);
    send_line(H, 1'b0);
    check("mid_no_writes", 32'(wr_cnt - wr_base), 32'd0);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.vsynch = 1'b1;
    tick(3);
    bus.vsynch = 1'b0;
    tick(2);
    send_line(H, 1'b1);
    send_line(H, 1'b1);
    m_col = 0;
    bus.href = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) pixel(4, 1'b1, 1'b0);
    tick(2);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    check_idle_outputs("abort");
    bus.href = 1'b0;
    tick(4);
    check("abort_no_frame_done", 32'(fd_cnt - fd_base), 32'd0);
    check("abort_writes", 32'(wr_cnt - wr_base), 32'(2 * H + 3));
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Reset in the middle of a capture.
    frame_start();
    send_line(H, 1'b1);
    bus.href = 1'b1;
    tick(1);
    m_col = 0;
    pixel(4, 1'b1, 1'b0);
    pixel(4, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    check("midreset_err", 32'(bus.err_flags), 32'd0);
    check("midreset_queue", 32'(exp_q.size()), 32'd0);
    bus.href = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);

    // Recovery: a clean frame after the reset.
    frame_start();
    for (int l = 0; l < V; l++) send_line(H, 1'b1);
    frame_finish("recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
